// File: rtl/norm_round_mod.sv
`default_nettype none
// ============================================================================
//  Module      : norm_round_mod
//  Description : Normalize / round / pack stage of the FP32 multiplier.
//                Takes the 48-bit mantissa product, the pre-biased exponent
//                sum and the result sign. Produces the packed IEEE-754
//                single-precision result with round-to-nearest-even and
//                overflow / underflow / inexact flags. There is no subnormal
//                support: underflow flushes to signed zero.
//                Two pipeline stages with a valid/ready handshake on both
//                sides. Runs at one beat per cycle and buffers up to two beats.
//  Ports       : clk, rst_n        - clock (rising edge), async active-low reset
//                in_valid/in_ready - input handshake
//                producto          - mantissa product, hidden bits included
//                exp_in            - signed exponent sum EA+EB-bias
//                sign_in           - result sign
//                out_valid/out_ready - output handshake
//                resultado         - packed {sign, exp, frac}
//                overflow, underflow, inexact - result flags
//  Revision    : 1.0 - initial release
// ============================================================================
module norm_round_mod #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int EXP_IW = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2*(FRAC_W+1)-1:0]        producto,
    input  logic signed [EXP_IW-1:0]       exp_in,
    input  logic                           sign_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_W+FRAC_W:0]          resultado,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           inexact
);

    localparam int c_PW = 2 * (FRAC_W + 1);
    localparam int c_RW = 1 + EXP_W + FRAC_W;
    // Exponents are carried as (EXP_IW+1)-bit two's complement so that the
    // +1 from normalization and the +1 from rounding carry can never wrap.
    localparam logic [EXP_IW:0] c_ONE     = (EXP_IW+1)'(1);
    localparam logic [EXP_IW:0] c_EXP_MAX = (EXP_IW+1)'((1 << EXP_W) - 1);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_load;
    logic w_s2_load;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: normalize
    // ------------------------------------------------------------------
    logic [EXP_IW:0]   w_e_ext;
    logic [FRAC_W-1:0] w_n_mant;
    logic              w_n_g;
    logic              w_n_s;
    logic [EXP_IW:0]   w_n_exp;

    always_comb begin
        w_e_ext = {exp_in[EXP_IW-1], exp_in};
        if (producto[c_PW-1]) begin
            // Product in [2,4): drop one more bit and bump the exponent.
            w_n_mant = producto[c_PW-2 -: FRAC_W];
            w_n_g    = producto[c_PW-2-FRAC_W];
            w_n_s    = |producto[c_PW-3-FRAC_W:0];
            w_n_exp  = w_e_ext + c_ONE;
        end else begin
            w_n_mant = producto[c_PW-3 -: FRAC_W];
            w_n_g    = producto[c_PW-3-FRAC_W];
            w_n_s    = |producto[c_PW-4-FRAC_W:0];
            w_n_exp  = w_e_ext;
        end
    end

    logic              r_s1_sign;
    logic              r_s1_zero;
    logic [FRAC_W-1:0] r_s1_mant;
    logic              r_s1_g;
    logic              r_s1_s;
    logic [EXP_IW:0]   r_s1_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_exp   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= sign_in;
                r_s1_zero <= (producto == '0);
                r_s1_mant <= w_n_mant;
                r_s1_g    <= w_n_g;
                r_s1_s    <= w_n_s;
                r_s1_exp  <= w_n_exp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic              w_round_up;
    logic [FRAC_W:0]   w_mant_inc;
    logic [EXP_IW:0]   w_e_rnd;
    logic              w_ovf_rng;
    logic              w_unf_rng;
    logic [c_RW-1:0]   w_res;
    logic              w_ovf;
    logic              w_unf;
    logic              w_inx;

    always_comb begin
        w_round_up = r_s1_g && (r_s1_s || r_s1_mant[0]);
        // Carry out of the fraction means it was all ones: fraction wraps to
        // zero and the exponent absorbs the carry.
        w_mant_inc = {1'b0, r_s1_mant} + {{FRAC_W{1'b0}}, w_round_up};
        w_e_rnd    = r_s1_exp + {{EXP_IW{1'b0}}, w_mant_inc[FRAC_W]};
        w_ovf_rng  = !w_e_rnd[EXP_IW] && (w_e_rnd >= c_EXP_MAX);
        w_unf_rng  = w_e_rnd[EXP_IW] || (w_e_rnd == '0);

        w_res = {r_s1_sign, {(c_RW-1){1'b0}}};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inx = 1'b0;
        if (r_s1_zero) begin
            // Exact zero product: signed zero, no flags.
        end else if (w_ovf_rng) begin
            w_res = {r_s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_unf_rng) begin
            w_unf = 1'b1;
            w_inx = 1'b1;
        end else begin
            w_res = {r_s1_sign, w_e_rnd[EXP_W-1:0], w_mant_inc[FRAC_W-1:0]};
            w_inx = r_s1_g || r_s1_s;
        end
    end

    logic [c_RW-1:0] r_res;
    logic            r_ovf;
    logic            r_unf;
    logic            r_inx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inx      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res <= w_res;
                r_ovf <= w_ovf;
                r_unf <= w_unf;
                r_inx <= w_inx;
            end
        end
    end

    assign resultado = r_res;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign inexact   = r_inx;

endmodule
`default_nettype wire

// File: tb/tb_norm_round_mod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_norm_round_mod
//  Description : Self-checking bench for norm_round_mod. Expected results come
//                from an integer-arithmetic model of normalize/RNE/range rules
//                and a queue of in-flight beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_round_mod;

    typedef struct packed {
        logic [31:0] r;
        logic        ovf;
        logic        unf;
        logic        inx;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [47:0]       producto = '0;
    logic signed [9:0] exp_in = '0;
    logic              sign_in = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       resultado;
    logic              overflow;
    logic              underflow;
    logic              inexact;

    always #5 clk = ~clk;

    norm_round_mod dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .producto  (producto),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    res_t    exp_q[$];
    int      n_chk = 0;
    int      n_pass = 0;
    int      gap = 0;
    bit      hold_prev = 0;
    res_t    hold_val;

    // Value-level model: fraction = product scaled so the leading one sits
    // just above the kept field; remainder compared against one half ULP.
    function automatic res_t model(input logic [47:0] p, input logic signed [9:0] e, input logic s);
        res_t   r;
        longint pv, q, rem, half, frac, one23;
        int     sh, ee;
        r = '0;
        r.r = {s, 31'h0};
        if (p == 48'h0) return r;
        pv    = longint'({16'h0, p});
        sh    = p[47] ? 24 : 23;
        ee    = int'(e) + (p[47] ? 1 : 0);
        one23 = longint'(1) << 23;
        q     = pv >> sh;
        rem   = pv & ((longint'(1) << sh) - 1);
        half  = longint'(1) << (sh - 1);
        frac  = q % one23;
        if (rem > half || (rem == half && (frac % 2) == 1)) frac = frac + 1;
        if (frac == one23) begin
            frac = 0;
            ee   = ee + 1;
        end
        if (ee >= 255) begin
            r.r = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; r.inx = 1'b1;
        end else if (ee <= 0) begin
            r.unf = 1'b1; r.inx = 1'b1;
        end else begin
            r.r   = {s, 8'(ee), 23'(frac)};
            r.inx = (rem != 0);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk = n_chk + 1;
        if (act === req) n_pass = n_pass + 1;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    // One clock cycle: drive inputs after the falling edge, then sample and
    // score the transfers that the next rising edge will perform.
    task automatic step(input bit v, input logic [47:0] p, input logic signed [9:0] e,
                        input bit s, input bit ordy, output bit took);
        res_t got;
        res_t x;
        @(negedge clk);
        in_valid = v; producto = p; exp_in = e; sign_in = s; out_ready = ordy;
        #1;
        got = {resultado, overflow, underflow, inexact};
        chk("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) || ordy));
        if (hold_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(got), 64'(hold_val));
        end
        hold_prev = out_valid && !ordy;
        hold_val  = got;
        if (exp_q.size() > 0 && !out_valid) begin
            gap = gap + 1;
            chk("bubble", 64'(gap), 64'd1);
        end else begin
            gap = 0;
        end
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else begin
                x = exp_q.pop_front();
                chk("result", 64'(got), 64'(x));
            end
        end
        took = v && in_ready;
        if (took) exp_q.push_back(model(p, e, s));
    endtask

    task automatic drain();
        bit t;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(0, '0, '0, 0, 1, t);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [47:0] rand_prod();
        logic [23:0] a, b;
        logic [47:0] p;
        int          k;
        k = int'($urandom_range(0, 15));
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
        p = 48'(a) * 48'(b);
        if (k == 0) p = '0;
        else if (k < 4) p = {16'($urandom), 32'($urandom)};
        else if (k < 7) p[21:0] = '0;           // produce exact ties
        return p;
    endfunction

    function automatic logic signed [9:0] rand_exp();
        case ($urandom_range(0, 3))
            0: return 10'(int'($urandom_range(100, 160)));
            1: return 10'(int'($urandom_range(240, 260)));
            2: return 10'(int'($urandom_range(0, 10)) - 5);
            default: return 10'($urandom);
        endcase
    endfunction

    logic [47:0]       d_p[6]  = '{48'h900000000000, 48'h400000400000, 48'h400000C00000,
                                   48'h7FFFFFC00000, 48'h800000000000, 48'h400000000000};
    logic signed [9:0] d_e[6]  = '{10'sd127, 10'sd127, 10'sd127, 10'sd127, 10'sd254, 10'sd0};
    logic              d_s[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        bit          t;
        int          acc;
        logic [47:0] bp_p[4];
        logic [9:0]  bp_e[4];

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'({resultado, overflow, underflow, inexact}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Hand-computed values pinning the model
        chk("pin_one",   64'(model(48'h400000000000, 10'sd127, 1'b0)), 64'({32'h3F800000, 3'b000}));
        chk("pin_2p25",  64'(model(48'h900000000000, 10'sd127, 1'b0)), 64'({32'h40100000, 3'b000}));
        chk("pin_tie",   64'(model(48'h400000400000, 10'sd127, 1'b0)), 64'({32'h3F800000, 3'b001}));
        chk("pin_rup",   64'(model(48'h400000C00000, 10'sd127, 1'b0)), 64'({32'h3F800002, 3'b001}));
        chk("pin_carry", 64'(model(48'h7FFFFFC00000, 10'sd127, 1'b0)), 64'({32'h40000000, 3'b001}));
        chk("pin_ovf",   64'(model(48'h800000000000, 10'sd254, 1'b1)), 64'({32'hFF800000, 3'b101}));
        chk("pin_unf",   64'(model(48'h400000000000, 10'sd0,   1'b0)), 64'({32'h00000000, 3'b011}));
        chk("pin_zero",  64'(model(48'h0,            10'sd100, 1'b1)), 64'({32'h80000000, 3'b000}));

        // Latency of a single beat
        step(1, 48'h400000000000, 10'sd127, 0, 1, t);
        chk("t1_accept", 64'(t), 64'd1);
        step(0, '0, '0, 0, 1, t);
        chk("t1_lat1", 64'(out_valid), 64'd0);
        step(0, '0, '0, 0, 1, t);
        chk("t1_lat2", 64'(out_valid), 64'd1);
        chk("t1_res", 64'({resultado, overflow, underflow, inexact}), 64'({32'h3F800000, 3'b000}));
        drain();

        // Directed values back to back
        for (int i = 0; i < 6; i++) step(1, d_p[i], d_e[i], d_s[i], 1, t);
        step(1, 48'h0, 10'sd50, 1, 1, t);
        drain();

        // Backpressure: 4 beats, downstream stalled for 3 cycles
        for (int i = 0; i < 4; i++) begin
            bp_p[i] = rand_prod();
            bp_e[i] = rand_exp();
        end
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, bp_p[acc], bp_e[acc], 0, 0, t);
            if (t) acc = acc + 1;
        end
        chk("bp_accepts", 64'(acc), 64'd2);
        for (int i = 0; i < 20 && acc < 4; i++) begin
            step(1, bp_p[acc], bp_e[acc], 1, 1, t);
            if (t) acc = acc + 1;
        end
        chk("bp_all_accepted", 64'(acc), 64'd4);
        drain();

        // Reset with two beats in flight
        step(1, 48'h400000000000, 10'sd127, 0, 0, t);
        step(1, 48'h900000000000, 10'sd127, 0, 0, t);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_result", 64'(resultado), 64'd0);
        exp_q.delete();
        hold_prev = 0;
        gap = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(0, '0, '0, 0, 1, t);

        // Random stream with random backpressure
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), rand_prod(), rand_exp(), 1'($urandom),
                 ($urandom_range(0, 9) < 7), t);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
